mod_bus_rx: RTL
===============

// Module: mod_bus_rx
// PURPOSE
//   Receive side of the dual-rail bus_t link driven by the main D-type register stage (Q plus inverted nQ).
//   Checks every cycle that nQ == ~Q and discards idle words (all-zero Q).
//   Buffers valid words in a small FIFO and presents them downstream on a valid/ready handshake.
//   Reports link lock, integrity errors and overflows.
// PARAMETERS
//   DEPTH      4   FIFO depth in bus_t words; power of two, >= 2
//   SYNC_IDLE  2   consecutive clean idle words required to enter LOCK
//   ERR_LIMIT  3   consecutive integrity errors that drop LOCK back to HUNT
//   CNT_W      8   width of the saturating error and overflow counters
// PORTS
//   i_clk      in   1                  clock, rising edge
//   i_rst_n    in   1                  asynchronous active-low reset
//   i_Q        in   bus_t              link data (Tag, Data)
//   i_nQ       in   bus_t              link data inverted
//   i_ready    in   1                  downstream accepts o_data this cycle
//   o_data     out  bus_t              FIFO head word
//   o_valid    out  1                  o_data valid
//   o_locked   out  1                  1 in LOCK state
//   o_err      out  1                  one-cycle pulse: integrity error seen
//   o_ovf      out  1                  one-cycle pulse: word dropped, FIFO full
//   o_err_cnt  out  CNT_W              saturating count of integrity errors
//   o_ovf_cnt  out  CNT_W              saturating count of overflow drops
//   o_level    out  $clog2(DEPTH)+1    FIFO occupancy
// BEHAVIOUR
//   Reset: asynchronous, active-low on i_rst_n; the clock is i_clk. All outputs are 0, state = HUNT, FIFO empty, counters 0.
//   Capture stage: i_Q/i_nQ registered each edge; classification uses the registered pair (1 cycle).
//   Classification of the captured pair:
//     ERROR = nQ != ~Q (any bit);
//     IDLE  = clean and Q == '0;
//     WORD  = clean and Q != '0.
//   FSM HUNT:
//     count consecutive IDLE; reaching SYNC_IDLE -> LOCK;
//     WORD or ERROR clears the count;
//     WORDs in HUNT are discarded and not counted.
//   FSM LOCK:
//     WORD -> FIFO push;
//     ERROR increments the consecutive-error count; reaching ERR_LIMIT -> HUNT;
//     any clean pair (IDLE or WORD) clears the count.
//   ERROR in either state: o_err pulses 1 cycle (the cycle after classification); o_err_cnt += 1, saturating at all-ones.
//     ERROR words are never pushed.
//   Latency: WORD on i_Q/i_nQ before edge k -> captured at k, pushed at k+1; o_valid = 1 after edge k+1.
//   FIFO:
//     o_valid = (o_level != 0); o_data = head word when valid, '0 when empty;
//     pop on o_valid & i_ready; o_data stays stable while o_valid & !i_ready.
//   Full:
//     a push with no pop -> word dropped, o_ovf pulses, o_ovf_cnt += 1 (saturating);
//     a push with a pop in the same cycle succeeds, and o_level is unchanged.
//   Empty: i_ready is ignored and no pop occurs. A push to an empty FIFO becomes visible the following cycle (no bypass).
//   Pointers wrap modulo DEPTH; o_level ranges 0..DEPTH.
//   Reset mid-operation: FIFO contents are flushed, counters cleared, and the FSM returns to HUNT immediately.
//   No word is presented after reset until LOCK is re-acquired.
// TESTING
//   T1 reset/lock: release reset, drive Q='0, nQ='1 for 2 cycles -> o_locked=1 after the 3rd edge.
//      Outputs stay 0 during reset.
//   T2 data path: LOCKed, i_ready=1, drive Tag=1/Data=0x5A with nQ=~Q for 1 cycle
//      -> o_valid=1 for 1 cycle, 2 edges later, with o_data Tag=1/Data=0x5A.
//   T3 integrity: flip nQ bit 0 for 1 cycle
//      -> o_err pulse, o_err_cnt=1, no push.
//      3 consecutive bad cycles -> o_locked=0; then 2 idles -> relock.
//   T4 overflow: i_ready=0, push 5 words with DEPTH=4
//      -> o_level=4, o_ovf once, o_ovf_cnt=1.
//      Then i_ready=1 -> the first 4 words pop out in order.
//   T5 full with simultaneous push and pop: FIFO full, i_ready=1 and a new WORD arrive together
//      -> no o_ovf, o_level stays 4, order preserved.
//   T6 saturation and reset: force 300 errors with CNT_W=8 -> o_err_cnt=255;
//      assert i_rst_n=0 mid-burst -> FIFO empty, counters 0, o_locked=0 immediately.

Source files
------------

// File: rtl/mod_bus_rx.sv
// mod_bus_rx: dual-rail link receiver with per-cycle integrity check, HUNT/LOCK
// framing FSM and a small output FIFO on a valid/ready handshake.
module mod_bus_rx #(
    parameter int DEPTH     = 4,
    parameter int SYNC_IDLE = 2,
    parameter int ERR_LIMIT = 3,
    parameter int CNT_W     = 8,
    parameter int DATA_W    = 8,
    localparam int W        = DATA_W + 1,
    localparam int AW       = $clog2(DEPTH),
    localparam int LW       = AW + 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic [W-1:0]     i_Q,
    input  logic [W-1:0]     i_nQ,
    input  logic             i_ready,
    output logic [W-1:0]     o_data,
    output logic             o_valid,
    output logic             o_locked,
    output logic             o_err,
    output logic             o_ovf,
    output logic [CNT_W-1:0] o_err_cnt,
    output logic [CNT_W-1:0] o_ovf_cnt,
    output logic [LW-1:0]    o_level
);
    localparam int SW = $clog2(SYNC_IDLE + 1);
    localparam int EW = $clog2(ERR_LIMIT + 1);

    typedef enum logic {HUNT, LOCK} state_t;

    state_t        state, state_nx;
    logic [W-1:0]  cap_q, cap_nq;
    logic          cap_v;
    logic [SW-1:0] idle_cnt, idle_nx;
    logic [EW-1:0] bad_cnt, bad_nx;
    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic          is_err, is_idle, is_word, push, pop, full, wr, drop;

    // cap_v keeps the reset value of the capture stage from being classified
    assign is_err   = cap_v && (cap_nq != ~cap_q);
    assign is_idle  = cap_v && !is_err && cap_q == '0;
    assign is_word  = cap_v && !is_err && cap_q != '0;
    assign push     = is_word && state == LOCK;
    assign pop      = o_valid && i_ready;
    assign full     = o_level == LW'(DEPTH);
    assign wr       = push && (!full || pop);
    assign drop     = push && full && !pop;
    assign o_valid  = o_level != '0;
    assign o_data   = o_valid ? mem[rd_ptr] : '0;
    assign o_locked = state == LOCK;

    always_comb begin
        state_nx = state;
        idle_nx  = idle_cnt;
        bad_nx   = bad_cnt;
        if (cap_v) begin
            if (state == HUNT) begin
                idle_nx = is_idle ? idle_cnt + 1'b1 : '0;
                if (is_idle && idle_cnt == SW'(SYNC_IDLE - 1)) begin
                    state_nx = LOCK;
                    idle_nx  = '0;
                end
            end else begin
                bad_nx = is_err ? bad_cnt + 1'b1 : '0;
                if (is_err && bad_cnt == EW'(ERR_LIMIT - 1)) begin
                    state_nx = HUNT;
                    bad_nx   = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= HUNT;
            cap_q     <= '0;
            cap_nq    <= '0;
            cap_v     <= 1'b0;
            idle_cnt  <= '0;
            bad_cnt   <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            o_level   <= '0;
            o_err     <= 1'b0;
            o_ovf     <= 1'b0;
            o_err_cnt <= '0;
            o_ovf_cnt <= '0;
        end else begin
            state    <= state_nx;
            idle_cnt <= idle_nx;
            bad_cnt  <= bad_nx;
            cap_q    <= i_Q;
            cap_nq   <= i_nQ;
            cap_v    <= 1'b1;
            o_err    <= is_err;
            o_ovf    <= drop;
            if (is_err && !(&o_err_cnt))
                o_err_cnt <= o_err_cnt + 1'b1;
            if (drop && !(&o_ovf_cnt))
                o_ovf_cnt <= o_ovf_cnt + 1'b1;
            if (wr)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            o_level <= o_level + LW'(wr) - LW'(pop);
        end
    end

    // Storage needs no reset: reset empties the FIFO through the pointers
    always_ff @(posedge i_clk) begin
        if (wr)
            mem[wr_ptr] <= cap_q;
    end
endmodule
